// File: rtl/fa16_pkg.sv
// ---------------------------------------------------------------------------
// fa16_pkg
// Shared definitions for the 16-entry fully-associative tag controller.
//   N_WAYS       : number of entries (and width of every one-hot way vector)
//   fa16_state_e : controller FSM states
// ---------------------------------------------------------------------------
package fa16_pkg;

  localparam int N_WAYS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMP   = 3'd1,
    ST_MISS  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FLUSH = 3'd4
  } fa16_state_e;

endpackage

// File: rtl/fa16_tag_ctrl_onehot16_first.sv
// ---------------------------------------------------------------------------
// onehot16_first
// Picks the lowest-index set bit of a 16-bit request vector.
// Ports:
//   req [N_WAYS] in  : candidate ways
//   sel [N_WAYS] out : one-hot lowest set bit of req (all zero if req == 0)
//   any          out : req has at least one bit set
// ---------------------------------------------------------------------------
module onehot16_first
  import fa16_pkg::*;
(
  input  logic [N_WAYS-1:0] req,
  output logic [N_WAYS-1:0] sel,
  output logic              any
);

  // Two's-complement trick: req & -req keeps only the lowest set bit
  always_comb begin
    sel = req & (~req + {{(N_WAYS-1){1'b0}}, 1'b1});
    any = |req;
  end

endmodule

// File: rtl/fa16_tag_ctrl.sv
// ---------------------------------------------------------------------------
// fa16_tag_ctrl
// 16-entry fully-associative tag store with miss/refill handshake and an
// external tree PLRU.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/ready, req_tag : lookup request handshake
//   resp_valid/hit/data      : one-cycle response pulse (hit or refill data)
//   miss_valid/ready/tag     : refill request handshake
//   refill_valid/data        : single-beat refill data (accepted in WAIT only)
//   flush                    : invalidate all entries (deferred if busy)
//   plru_hit, plru_hit_sel   : touch pulse + one-hot way to the PLRU
//   plru_wen, plru_victim    : victim request + combinational one-hot answer
// The plru_* outputs are combinational because the victim must be consumed
// in the same cycle the PLRU is asked for it.
// ---------------------------------------------------------------------------
module fa16_tag_ctrl
  import fa16_pkg::*;
#(
  parameter int TAG_W  = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  output logic              miss_valid,
  input  logic              miss_ready,
  output logic [TAG_W-1:0]  miss_tag,
  input  logic              refill_valid,
  input  logic [DATA_W-1:0] refill_data,
  input  logic              flush,
  output logic              plru_hit,
  output logic [N_WAYS-1:0] plru_hit_sel,
  output logic              plru_wen,
  input  logic [N_WAYS-1:0] plru_victim
);

  fa16_state_e       state_r;
  logic [N_WAYS-1:0] valid_r;
  logic              flush_pend_r;
  logic [TAG_W-1:0]  cap_tag_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic              resp_hit_r;
  logic [DATA_W-1:0] resp_data_r;
  logic              miss_valid_r;
  logic [TAG_W-1:0]  miss_tag_r;

  logic [TAG_W-1:0]  tag_mem_r  [N_WAYS];
  logic [DATA_W-1:0] data_mem_r [N_WAYS];

  logic [N_WAYS-1:0] match_s;
  logic [N_WAYS-1:0] hit_sel_s;
  logic              hit_any_s;
  logic [N_WAYS-1:0] inv_sel_s;
  logic              inv_any_s;
  logic [N_WAYS-1:0] victim_sel_s;
  logic [DATA_W-1:0] hit_data_s;

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_hit   = resp_hit_r;
  assign resp_data  = resp_data_r;
  assign miss_valid = miss_valid_r;
  assign miss_tag   = miss_tag_r;

  // Parallel compare of the captured tag against every valid entry
  always_comb begin
    match_s = {N_WAYS{1'b0}};
    for (int i = 0; i < N_WAYS; i++) begin
      match_s[i] = valid_r[i] && (tag_mem_r[i] == cap_tag_r);
    end
  end

  // Multiple matches resolve to the lowest index
  onehot16_first u_hit_first (
    .req (match_s),
    .sel (hit_sel_s),
    .any (hit_any_s)
  );

  // Lowest-index free entry is preferred over asking the PLRU
  onehot16_first u_inv_first (
    .req (~valid_r),
    .sel (inv_sel_s),
    .any (inv_any_s)
  );

  // AND-OR mux of the payload selected by the one-hot hit vector
  always_comb begin
    hit_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_WAYS; i++) begin
      hit_data_s = hit_data_s | (data_mem_r[i] & {DATA_W{hit_sel_s[i]}});
    end
  end

  // PLRU touch / victim request and the way written by a refill
  always_comb begin
    plru_hit     = 1'b0;
    plru_hit_sel = {N_WAYS{1'b0}};
    plru_wen     = 1'b0;
    victim_sel_s = {N_WAYS{1'b0}};
    case (state_r)
      ST_CMP: begin
        if (hit_any_s) begin
          plru_hit     = 1'b1;
          plru_hit_sel = hit_sel_s;
        end else begin
          plru_hit     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (refill_valid) begin
          if (inv_any_s) begin
            plru_hit     = 1'b1;
            plru_hit_sel = inv_sel_s;
            victim_sel_s = inv_sel_s;
          end else begin
            plru_wen     = 1'b1;
            victim_sel_s = plru_victim;
          end
        end else begin
          plru_wen = 1'b0;
        end
      end
      default: begin
        plru_hit = 1'b0;
      end
    endcase
  end

  // Tag/data storage: written only by a refill, never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_WAYS; i++) begin
      if (victim_sel_s[i]) begin
        tag_mem_r[i]  <= cap_tag_r;
        data_mem_r[i] <= refill_data;
      end
    end
  end

  // Controller FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      valid_r      <= {N_WAYS{1'b0}};
      flush_pend_r <= 1'b0;
      cap_tag_r    <= {TAG_W{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_data_r  <= {DATA_W{1'b0}};
      miss_valid_r <= 1'b0;
      miss_tag_r   <= {TAG_W{1'b0}};
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready_r) begin
            // A flush racing the accept is deferred behind this lookup
            cap_tag_r    <= req_tag;
            flush_pend_r <= flush;
            req_ready_r  <= 1'b0;
            state_r      <= ST_CMP;
          end else if (flush_pend_r || flush) begin
            flush_pend_r <= 1'b0;
            req_ready_r  <= 1'b0;
            state_r      <= ST_FLUSH;
          end else begin
            req_ready_r  <= 1'b1;
          end
        end
        ST_CMP: begin
          flush_pend_r <= flush_pend_r | flush;
          if (hit_any_s) begin
            resp_valid_r <= 1'b1;
            resp_hit_r   <= 1'b1;
            resp_data_r  <= hit_data_s;
            req_ready_r  <= ~(flush_pend_r | flush);
            state_r      <= ST_IDLE;
          end else begin
            miss_valid_r <= 1'b1;
            miss_tag_r   <= cap_tag_r;
            state_r      <= ST_MISS;
          end
        end
        ST_MISS: begin
          flush_pend_r <= flush_pend_r | flush;
          if (miss_ready) begin
            miss_valid_r <= 1'b0;
            state_r      <= ST_WAIT;
          end else begin
            miss_valid_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          flush_pend_r <= flush_pend_r | flush;
          if (refill_valid) begin
            valid_r      <= valid_r | victim_sel_s;
            resp_valid_r <= 1'b1;
            resp_hit_r   <= 1'b0;
            resp_data_r  <= refill_data;
            req_ready_r  <= ~(flush_pend_r | flush);
            state_r      <= ST_IDLE;
          end else begin
            state_r      <= ST_WAIT;
          end
        end
        ST_FLUSH: begin
          // Clearing here also covers a flush that arrives during this cycle
          valid_r     <= {N_WAYS{1'b0}};
          req_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          miss_valid_r <= 1'b0;
          req_ready_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
